// File: rtl/video_sig_recover_if.sv
// ---------------------------------------------------------------------------
// video_sig_recover_if
// Bundles the sync/data inputs from the video source and the recovered
// timing outputs of video_sig_recover. The master modport is the source side
// (it drives hs/vs/ad and observes results). The slave modport is the
// recovery block.
// Optional macro: TIMING_MEASURE_EN adds h_total_out / v_total_out.
// ---------------------------------------------------------------------------
interface video_sig_recover_if #(
    parameter int H_TOTAL = 1650,
    parameter int V_TOTAL = 750
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic          hs_in;
    logic          vs_in;
    logic          ad_in;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic          ad_out;
    logic          nf_out;
    logic [5:0]    fc_out;
    logic          line_err_out;
    logic          locked_out;
`ifdef TIMING_MEASURE_EN
    logic [HW:0]   h_total_out;
    logic [VW:0]   v_total_out;

    modport master (
        output hs_in, vs_in, ad_in,
        input  hcount_out, vcount_out, ad_out, nf_out, fc_out,
        input  line_err_out, locked_out, h_total_out, v_total_out
    );
    modport slave (
        input  hs_in, vs_in, ad_in,
        output hcount_out, vcount_out, ad_out, nf_out, fc_out,
        output line_err_out, locked_out, h_total_out, v_total_out
    );
`else
    modport master (
        output hs_in, vs_in, ad_in,
        input  hcount_out, vcount_out, ad_out, nf_out, fc_out,
        input  line_err_out, locked_out
    );
    modport slave (
        input  hs_in, vs_in, ad_in,
        output hcount_out, vcount_out, ad_out, nf_out, fc_out,
        output line_err_out, locked_out
    );
`endif
endinterface

// File: rtl/video_sig_recover.sv
// ---------------------------------------------------------------------------
// video_sig_recover
// Receive-side timing recovery. It samples hs/vs/ad once and derives edges
// against that sample. It recovers the active pixel/line coordinates, pulses
// nf_out and advances fc_out on every vs rise, and checks line width and line
// count. It asserts locked_out after LOCK_FRAMES consecutive good frames.
// All outputs are registered, so each output lags its input by one cycle.
// Optional macro: TIMING_MEASURE_EN adds hs-period and lines-per-frame
// measurement (h_total_out / v_total_out). The measurement does not affect lock.
// ---------------------------------------------------------------------------
module video_sig_recover #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int H_TOTAL         = 1650,
    parameter int V_TOTAL         = 750,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic              clk_pixel_in,
    input  logic              rst_in,
    video_sig_recover_if.slave bus
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int LW = $clog2(LOCK_FRAMES + 1);

    localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [VW-1:0] V_ONE    = VW'(1);
    localparam logic [LW-1:0] L_ONE    = LW'(1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);

    logic          r_vs;
    logic          r_ad;
    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic          r_nf;
    logic [5:0]    r_fc;
    logic          r_line_err;
    logic          r_locked;
    logic [LW-1:0] r_lock_cnt;
    logic          r_frame_ok;

    logic          w_ad_rise;
    logic          w_ad_fall;
    logic          w_vs_rise;
    logic [HW-1:0] w_hcount_inc;
    logic [VW-1:0] w_vcount_inc;
    logic [LW-1:0] w_lock_inc;
    logic          w_line_bad;
    logic [VW-1:0] w_lines;
    logic          w_frame_good;

    // Edges compare the live inputs against the previous sample.
    assign w_ad_rise    = bus.ad_in & ~r_ad;
    assign w_ad_fall    = ~bus.ad_in & r_ad;
    assign w_vs_rise    = bus.vs_in & ~r_vs;
    assign w_hcount_inc = (r_hcount == H_MAX) ? r_hcount : r_hcount + H_ONE;
    assign w_vcount_inc = (r_vcount == V_MAX) ? r_vcount : r_vcount + V_ONE;
    assign w_lock_inc   = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : r_lock_cnt + L_ONE;

    // Line verdict first; the frame verdict then counts the line that is closing now.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        w_line_bad = 1'b0;
        w_lines    = r_vcount;
        if (w_ad_fall) begin
            // A saturated hcount means the line overran, so it is always a wrong length.
            w_line_bad = (r_hcount == H_MAX) || (int'(r_hcount) + 1 != ACTIVE_H_PIXELS);
            w_lines    = w_vcount_inc;
        end
        w_frame_good = r_frame_ok && !w_line_bad &&
                       (int'(w_lines) == ACTIVE_LINES) && !bus.ad_in;
    end

    // Input sample stage plus the single-cycle pulse outputs.
    always_ff @(posedge clk_pixel_in) begin
        // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
        if (rst_in) begin
            r_vs       <= 1'b0;
            r_ad       <= 1'b0;
            r_nf       <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_vs       <= bus.vs_in;
            r_ad       <= bus.ad_in;
            r_nf       <= w_vs_rise;
            r_line_err <= w_line_bad;
        end
    end

    // Pixel and line coordinates inside the active region.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            if (w_ad_rise) begin
                r_hcount <= '0;
            end else if (bus.ad_in && r_ad) begin
                r_hcount <= w_hcount_inc;
            end
            if (w_vs_rise) begin
                r_vcount <= '0;
            end else if (w_ad_fall) begin
                r_vcount <= w_vcount_inc;
            end
        end
    end

    // Frame counting and lock tracking. frame_ok starts cleared, so the partial first frame is always judged bad.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_fc       <= '0;
            r_frame_ok <= 1'b0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (w_vs_rise) begin
            r_fc       <= r_fc + 6'd1;
            r_frame_ok <= 1'b1;
            if (w_frame_good) begin
                r_lock_cnt <= w_lock_inc;
                r_locked   <= (w_lock_inc == LOCK_MAX);
            end else begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end
        end else if (w_line_bad) begin
            r_frame_ok <= 1'b0;
        end
    end

    assign bus.hcount_out   = r_hcount;
    assign bus.vcount_out   = r_vcount;
    assign bus.ad_out       = r_ad;
    assign bus.nf_out       = r_nf;
    assign bus.fc_out       = r_fc;
    assign bus.line_err_out = r_line_err;
    assign bus.locked_out   = r_locked;

`ifdef TIMING_MEASURE_EN
    logic          r_hs;
    logic [HW:0]   r_hcyc;
    logic [HW:0]   r_h_total;
    logic [VW:0]   r_vhs;
    logic [VW:0]   r_v_total;
    logic          w_hs_rise;

    assign w_hs_rise = bus.hs_in & ~r_hs;

    // hs period in cycles and hs rises per frame. An hs rise that coincides with a vs rise belongs to the new frame.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_hs      <= 1'b0;
            r_hcyc    <= '0;
            r_h_total <= '0;
            r_vhs     <= '0;
            r_v_total <= '0;
        end else begin
            r_hs <= bus.hs_in;
            if (w_hs_rise) begin
                r_h_total <= r_hcyc;
                r_hcyc    <= (HW+1)'(1);
            end else if (r_hcyc != '1) begin
                r_hcyc <= r_hcyc + (HW+1)'(1);
            end
            if (w_vs_rise) begin
                r_v_total <= r_vhs;
                r_vhs     <= (VW+1)'(w_hs_rise);
            end else if (w_hs_rise && r_vhs != '1) begin
                r_vhs <= r_vhs + (VW+1)'(1);
            end
        end
    end

    assign bus.h_total_out = r_h_total;
    assign bus.v_total_out = r_v_total;
`endif
endmodule

// File: tb/tb_video_sig_recover.sv
// ---------------------------------------------------------------------------
// tb_video_sig_recover
// Bench for video_sig_recover with small geometry (8x4 active, 12x7 total).
// A short table of cycle vectors is followed by hand-built streams for the
// multi-cycle corners and then random streams. Every cycle is compared against
// a reference model. The model keeps run lengths, line counts and a good-frame
// streak as plain integers.
// Optional macro: TIMING_MEASURE_EN also compares h_total_out / v_total_out.
// ---------------------------------------------------------------------------
module tb_video_sig_recover;
    localparam int ACT_H = 8;
    localparam int ACT_L = 4;
    localparam int H_T   = 12;
    localparam int V_T   = 7;
    localparam int LOCKN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_sig_recover_if #(.H_TOTAL(H_T), .V_TOTAL(V_T)) bus ();

    video_sig_recover #(
        .ACTIVE_H_PIXELS(ACT_H), .ACTIVE_LINES(ACT_L),
        .H_TOTAL(H_T), .V_TOTAL(V_T), .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk_pixel_in(clk),
        .rst_in      (rst),
        .bus         (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_cyc = 0, m_run = 0, m_hc = 0, m_lines = 0, m_streak = 0, m_frames = 0;
    bit m_prev_ad = 0, m_prev_vs = 0, m_prev_hs = 0, m_bad_line = 0, m_seen_vs = 0;
    bit m_nf = 0, m_le = 0;
    int m_last_hs = 0, m_hs_in_frame = 0, m_h_total = 0, m_v_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, m_cyc, act, exp);
        end
    endtask

    // Applies the spec rules to the inputs sampled at this edge.
    task automatic model_update();
        bit ad, vs, hs, hs_rise;
        m_cyc++;
        ad = bus.ad_in; vs = bus.vs_in; hs = bus.hs_in;
        if (rst) begin
            m_run = 0; m_hc = 0; m_lines = 0; m_streak = 0; m_frames = 0;
            m_prev_ad = 0; m_prev_vs = 0; m_prev_hs = 0; m_bad_line = 0; m_seen_vs = 0;
            m_nf = 0; m_le = 0; m_last_hs = m_cyc + 1; m_hs_in_frame = 0;
            m_h_total = 0; m_v_total = 0;
            return;
        end
        m_nf = 0; m_le = 0;
        hs_rise = hs && !m_prev_hs;
        if (ad) begin
            if (!m_prev_ad) m_run = 0;
            m_run++;
            m_hc = (m_run - 1 < H_T - 1) ? m_run - 1 : H_T - 1;
        end
        if (!ad && m_prev_ad) begin
            m_lines++;
            if (m_run != ACT_H || m_run >= H_T) begin
                m_le = 1; m_bad_line = 1;
            end
        end
        if (hs_rise) begin
            m_h_total = (m_cyc - m_last_hs > 31) ? 31 : m_cyc - m_last_hs;
            m_last_hs = m_cyc;
        end
        if (vs && !m_prev_vs) begin
            if (m_seen_vs && !m_bad_line && m_lines == ACT_L && !ad) m_streak++;
            else m_streak = 0;
            m_frames++; m_nf = 1; m_lines = 0; m_bad_line = 0; m_seen_vs = 1;
            m_v_total = (m_hs_in_frame > 15) ? 15 : m_hs_in_frame;
            m_hs_in_frame = hs_rise ? 1 : 0;
        end else if (hs_rise) begin
            m_hs_in_frame++;
        end
        m_prev_ad = ad; m_prev_vs = vs; m_prev_hs = hs;
    endtask

    task automatic compare_model();
        check("hcount", 32'(bus.hcount_out), m_hc);
        check("vcount", 32'(bus.vcount_out), (m_lines > V_T - 1) ? V_T - 1 : m_lines);
        check("ad_out", 32'(bus.ad_out), 32'(m_prev_ad));
        check("nf_out", 32'(bus.nf_out), 32'(m_nf));
        check("fc_out", 32'(bus.fc_out), m_frames % 64);
        check("line_err", 32'(bus.line_err_out), 32'(m_le));
        check("locked", 32'(bus.locked_out), 32'(m_streak >= LOCKN));
`ifdef TIMING_MEASURE_EN
        check("h_total", 32'(bus.h_total_out), m_h_total);
        check("v_total", 32'(bus.v_total_out), m_v_total);
`endif
    endtask

    // One clock: drive, let the edge pass, update the model, sample 1 time unit later.
    task automatic step(input logic r, input logic hs, input logic vs, input logic ad, input bit cmp);
        rst = r; bus.hs_in = hs; bus.vs_in = vs; bus.ad_in = ad;
        @(posedge clk);
        model_update();
        #1;
        if (cmp) compare_model();
    endtask

    // One line: ad high for len cycles, hs near the end, at least H_T cycles long.
    task automatic send_line(input int len, input bit vs_line);
        int total;
        total = (len + 2 > H_T) ? len + 2 : H_T;
        for (int c = 0; c < total; c++)
            step(1'b0, (c >= total - 3 && c < total - 1), vs_line, (c < len), 1'b1);
    endtask

    // Active lines first, one blank line, then a vs line, padded to V_T lines.
    task automatic send_frame(input int n_lines, input int bad_idx, input int bad_len);
        int total_lines;
        total_lines = (n_lines + 3 > V_T) ? n_lines + 3 : V_T;
        for (int l = 0; l < total_lines; l++)
            send_line((l < n_lines) ? ((l == bad_idx) ? bad_len : ACT_H) : 0, (l == n_lines + 1));
    endtask

    // Three good lines, then a fourth of width len whose ad fall meets the vs rise.
    task automatic coincident_frame(input int len, input bit exp_err, input bit exp_lock);
        for (int l = 0; l < 3; l++) send_line(ACT_H, 1'b0);
        for (int c = 0; c < len; c++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("coinc.nf", 32'(bus.nf_out), 1);
        check("coinc.line_err", 32'(bus.line_err_out), 32'(exp_err));
        check("coinc.locked", 32'(bus.locked_out), 32'(exp_lock));
        check("coinc.vcount", 32'(bus.vcount_out), 0);
        for (int c = 1; c < H_T; c++) step(1'b0, (c == 9 || c == 10), 1'b1, 1'b0, 1'b1);
        send_line(0, 1'b0);
    endtask

    typedef struct {
        logic       rst, vs, ad;
        logic [3:0] hc;
        logic [2:0] vc;
        logic       ado, nf;
        logic [5:0] fc;
        logic       le, lk;
    } vec_t;

    vec_t tbl [12];
    int   n_rand, bad_i, bad_l;

    initial begin
        bus.hs_in = 1'b0; bus.vs_in = 1'b0; bus.ad_in = 1'b0;
        tbl = '{
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0},   // reset: everything 0
            '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0},   // vs rise -> nf, fc=1
            '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0},   // vs held: no second pulse
            '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0},   // first ad sample -> hcount 0
            '{0, 0, 1, 1, 0, 1, 0, 1, 0, 0},
            '{0, 0, 1, 2, 0, 1, 0, 1, 0, 0},
            '{0, 0, 0, 2, 1, 0, 0, 1, 1, 0},   // 3-pixel line -> line_err, vcount 1
            '{0, 0, 0, 2, 1, 0, 0, 1, 0, 0},   // hcount holds while ad low
            '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0},
            '{0, 1, 1, 1, 0, 1, 1, 2, 0, 0},   // vs rise with ad high: bad frame
            '{0, 1, 0, 1, 1, 0, 0, 2, 1, 0},   // ad during vs counts as a line
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0}
        };
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, 1'b0, tbl[i].vs, tbl[i].ad, 1'b0);
            check($sformatf("tbl%0d.hcount", i), 32'(bus.hcount_out), 32'(tbl[i].hc));
            check($sformatf("tbl%0d.vcount", i), 32'(bus.vcount_out), 32'(tbl[i].vc));
            check($sformatf("tbl%0d.ad_out", i), 32'(bus.ad_out), 32'(tbl[i].ado));
            check($sformatf("tbl%0d.nf", i), 32'(bus.nf_out), 32'(tbl[i].nf));
            check($sformatf("tbl%0d.fc", i), 32'(bus.fc_out), 32'(tbl[i].fc));
            check($sformatf("tbl%0d.line_err", i), 32'(bus.line_err_out), 32'(tbl[i].le));
            check($sformatf("tbl%0d.locked", i), 32'(bus.locked_out), 32'(tbl[i].lk));
        end

        // Nominal stream: lock appears at the third nf (the first frame is partial).
        for (int f = 0; f < 3; f++) send_frame(ACT_L, -1, 0);
        check("nominal.locked", 32'(bus.locked_out), 1);
        check("nominal.fc", 32'(bus.fc_out), 3);
`ifdef TIMING_MEASURE_EN
        check("nominal.h_total", 32'(bus.h_total_out), 12);
        check("nominal.v_total", 32'(bus.v_total_out), 7);
`endif

        // Line 2 nine pixels wide: lock drops, then returns after two good frames.
        send_frame(ACT_L, 2, 9);
        check("wide.locked", 32'(bus.locked_out), 0);
        check("wide.fc", 32'(bus.fc_out), 4);
        send_frame(ACT_L, -1, 0);
        check("relock1.locked", 32'(bus.locked_out), 0);
        send_frame(ACT_L, -1, 0);
        check("relock2.locked", 32'(bus.locked_out), 1);

        // Five active lines: lock drops, fc still advances.
        send_frame(5, -1, 0);
        check("five.locked", 32'(bus.locked_out), 0);
        check("five.fc", 32'(bus.fc_out), 7);
        send_frame(ACT_L, -1, 0);
        send_frame(ACT_L, -1, 0);

        // ad fall and vs rise in the same cycle.
        coincident_frame(ACT_H, 1'b0, 1'b1);
        send_frame(ACT_L, -1, 0);
        coincident_frame(9, 1'b1, 1'b0);
        send_frame(ACT_L, -1, 0);
        send_frame(ACT_L, -1, 0);
        check("coinc.relock", 32'(bus.locked_out), 1);

        // 64 more frames: fc wraps back to the same value.
        for (int f = 0; f < 64; f++) send_frame(ACT_L, -1, 0);
        check("wrap.fc", 32'(bus.fc_out), 14);
        check("wrap.locked", 32'(bus.locked_out), 1);

        // ad held for 20 cycles: hcount saturates at H_TOTAL-1.
        send_line(20, 1'b0);
        check("hold.hcount", 32'(bus.hcount_out), 11);
        for (int f = 0; f < 3; f++) send_frame(ACT_L, -1, 0);
        check("hold.relock", 32'(bus.locked_out), 1);

        // Reset mid-line while locked.
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst.hcount", 32'(bus.hcount_out), 0);
        check("rst.ad_out", 32'(bus.ad_out), 0);
        check("rst.fc", 32'(bus.fc_out), 0);
        check("rst.locked", 32'(bus.locked_out), 0);
        for (int f = 0; f < 2; f++) send_frame(ACT_L, -1, 0);
        check("rst.not_yet", 32'(bus.locked_out), 0);
        send_frame(ACT_L, -1, 0);
        check("rst.relock", 32'(bus.locked_out), 1);
        check("rst.fc3", 32'(bus.fc_out), 3);

        // Random frames with occasional wrong widths and line counts.
        for (int f = 0; f < 40; f++) begin
            n_rand = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : ACT_L;
            bad_i  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n_rand - 1)) : -1;
            bad_l  = int'($urandom_range(6, 10));
            send_frame(n_rand, bad_i, bad_l);
        end
        // Unstructured random inputs with rare resets.
        for (int c = 0; c < 300; c++)
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
